// File: rtl/mdu_multicycle.sv
// mdu_multicycle: parametrised multi-cycle multiply/divide unit with HI/LO registers
// ports: clk, reset (async, active high); start/op/rs/rt issue an op, req cancels or blocks it;
//        busy while an op runs, done pulses after a commit, dz flags a zero divisor, hi/lo results
module mdu_multicycle #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             req,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2((MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT) + 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] a, b, dbs, dbu, qs, rms, qu, rmu;
    logic [3:0] opr;
    logic [2*WIDTH-1:0] ps, pu, acc, res;
    logic accept, arith, div_op, is_div, commit;
    assign accept = start && !busy && !req && op != 4'd0 && op <= 4'd10;
    assign arith  = accept && op <= 4'd8;
    assign div_op = op == 4'd3 || op == 4'd4;
    assign is_div = opr == 4'd3 || opr == 4'd4;
    assign commit = state == RUN && !req && cnt == CW'(1);
    assign acc    = {hi, lo};
    assign ps     = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign pu     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    // Zero divisors and signed MIN/-1 divide by 1 instead: zero is never committed,
    // and MIN/1 already gives the required quotient MIN with remainder 0.
    assign dbu    = (b == '0) ? WIDTH'(1) : b;
    assign dbs    = (b == '0 || (a == MIN && b == '1)) ? WIDTH'(1) : b;
    assign qs     = $signed(a) / $signed(dbs);
    assign rms    = $signed(a) % $signed(dbs);
    assign qu     = a / dbu;
    assign rmu    = a % dbu;
    assign res    = opr == 4'd1 ? ps :
                    opr == 4'd2 ? pu :
                    opr == 4'd3 ? {rms, qs} :
                    opr == 4'd4 ? {rmu, qu} :
                    opr == 4'd5 ? acc + ps :
                    opr == 4'd6 ? acc + pu :
                    opr == 4'd7 ? acc - ps :
                    opr == 4'd8 ? acc - pu : acc;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end
    always_comb begin
        nxt = state == IDLE ? (arith ? RUN : IDLE) : ((req || cnt == CW'(1)) ? IDLE : RUN);
    end
    always_comb begin
        busy = state == RUN;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            a    <= '0;
            b    <= '0;
            opr  <= '0;
            hi   <= '0;
            lo   <= '0;
            dz   <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= commit;
            if (arith) begin
                a   <= rs;
                b   <= rt;
                opr <= op;
                cnt <= div_op ? CW'(DIV_LAT) : CW'(MULT_LAT);
                if (div_op) dz <= 1'b0;
            end else if (busy) begin
                cnt <= req ? '0 : cnt - CW'(1);
            end
            if (accept && op == 4'd9)  hi <= rs;
            if (accept && op == 4'd10) lo <= rs;
            if (commit) begin
                if (is_div && b == '0) dz <= 1'b1;
                else {hi, lo} <= res;
            end
        end
    end
endmodule

// File: tb/tb_mdu_multicycle.sv
// tb_mdu_multicycle: directed vector bench for mdu_multicycle (32-bit and 16-bit instances)
module tb_mdu_multicycle;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0, req = 1'b0, busy, done, dz;
    logic [3:0] op = 4'd0;
    logic [31:0] rs = '0, rt = '0, hi, lo;
    logic start16 = 1'b0, busy16, done16, dz16;
    logic [3:0] op16 = 4'd0;
    logic [15:0] rs16 = '0, rt16 = '0, hi16, lo16;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    mdu_multicycle u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt), .req(req),
        .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
    );

    mdu_multicycle #(.WIDTH(16), .MULT_LAT(1), .DIV_LAT(2)) u_dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(op16), .rs(rs16), .rt(rt16), .req(1'b0),
        .busy(busy16), .done(done16), .dz(dz16), .hi(hi16), .lo(lo16)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dz;
        int          lat;
    } vec_t;
    vec_t v[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Called on a negedge; returns on the first negedge with busy low, n = busy cycles seen.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, output int n);
        start = 1'b1; op = o; rs = x; rt = y;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        v[0]  = '{4'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0, 5};
        v[1]  = '{4'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 5};
        v[2]  = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 10};
        v[3]  = '{4'd4, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 1'b0, 10};
        v[4]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 10};
        v[5]  = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 10};
        v[6]  = '{4'd3, 32'd5,        32'd0,        32'h00000001, 32'hFFFFFFFD, 1'b1, 10};
        v[7]  = '{4'd4, 32'd10,       32'd3,        32'h00000001, 32'h00000003, 1'b0, 10};
        v[8]  = '{4'd9, 32'd0,        32'd0,        32'h00000000, 32'h00000003, 1'b0, 0};
        v[9]  = '{4'd10, 32'hFFFFFFFF, 32'd0,       32'h00000000, 32'hFFFFFFFF, 1'b0, 0};
        v[10] = '{4'd5, 32'd1,        32'd1,        32'h00000001, 32'h00000000, 1'b0, 5};
        v[11] = '{4'd8, 32'd1,        32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0, 5};
        v[12] = '{4'd7, 32'd2,        32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 5};
        v[13] = '{4'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002, 1'b0, 5};
        v[14] = '{4'd1, 32'd3,        32'd4,        32'h00000000, 32'h0000000C, 1'b0, 5};

        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset dz", dz, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);

        for (int i = 0; i < 15; i++) begin
            issue(v[i].op, v[i].a, v[i].b, n);
            check($sformatf("v%0d busy cycles", i), n, v[i].lat);
            check($sformatf("v%0d done pulse", i), done, v[i].lat > 0);
            @(negedge clk);
            check($sformatf("v%0d done low", i), done, 0);
            check($sformatf("v%0d hi", i), hi, v[i].hi);
            check($sformatf("v%0d lo", i), lo, v[i].lo);
            check($sformatf("v%0d dz", i), dz, v[i].dz);
        end

        // abort on the third busy cycle
        issue(4'd9, 32'h55, 0, n);
        issue(4'd10, 32'h55, 0, n);
        start = 1'b1; op = 4'd1; rs = 32'd3; rt = 32'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort busy before req", busy, 1);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("abort busy drops", busy, 0);
        check("abort no done", done, 0);
        @(negedge clk);
        check("abort no done later", done, 0);
        check("abort hi", hi, 32'h55);
        check("abort lo", lo, 32'h55);

        // start with req on the issue edge is refused, including mthi
        start = 1'b1; req = 1'b1; op = 4'd1; rs = 32'd3; rt = 32'd4;
        @(negedge clk);
        check("req blocks mult", busy, 0);
        op = 4'd9; rs = 32'h99;
        @(negedge clk);
        start = 1'b0; req = 1'b0;
        check("req blocks mthi", hi, 32'h55);
        @(negedge clk);
        check("req blocks busy later", busy, 0);

        // second start while busy is ignored; start right after done is accepted
        start = 1'b1; op = 4'd1; rs = 32'd3; rt = 32'd4;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 2) begin start = 1'b1; op = 4'd2; rs = 32'd5; rt = 32'd5; end
            @(negedge clk);
            start = 1'b0;
        end
        check("b2b busy cycles", n, 5);
        check("b2b done", done, 1);
        check("b2b lo", lo, 32'hC);
        issue(4'd1, 32'd2, 32'd3, n);
        check("b2b second busy", n, 5);
        check("b2b second lo", lo, 32'h6);
        check("b2b second hi", hi, 32'h0);

        // 16-bit, single-cycle multiply
        start16 = 1'b1; op16 = 4'd1; rs16 = 16'h8000; rt16 = 16'h8000;
        @(negedge clk);
        start16 = 1'b0;
        n = 0;
        while (busy16 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("w16 busy cycles", n, 1);
        check("w16 done", done16, 1);
        check("w16 hi", hi16, 16'h4000);
        check("w16 lo", lo16, 16'h0000);

        // async reset mid-run with dz set and hi/lo nonzero
        issue(4'd3, 32'd5, 32'd0, n);
        check("pre-reset dz", dz, 1);
        issue(4'd10, 32'h77, 0, n);
        start = 1'b1; op = 4'd1; rs = 32'd3; rt = 32'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre-reset busy", busy, 1);
        #1 reset = 1'b1;
        #1;
        check("async reset busy", busy, 0);
        check("async reset hi", hi, 0);
        check("async reset lo", lo, 0);
        check("async reset dz", dz, 0);
        check("async reset done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("after reset busy", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mdu_multicycle.md
Name: mdu_multicycle

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the EX stage of the 5-stage pipeline; successor to the fixed 32-bit MDU.
- Adds configurable width and independent mult/div latencies.
- Adds madd/maddu/msub/msubu accumulate ops, a divide-by-zero flag and a one-cycle done pulse.
- Aborts an in-flight op on the exception request (req) so HI/LO are never committed by a cancelled instruction.

Parameters:
WIDTH, 32, operand/HI/LO width in bits (>=8)
MULT_LAT, 5, cycles busy for mult/multu/madd/maddu/msub/msubu (>=1)
DIV_LAT, 10, cycles busy for div/divu (>=1)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-high reset
start  in  1  issue strobe from EX stage
op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 maddu, 7 msub, 8 msubu, 9 mthi, 10 mtlo; 11-15 no-op
rs  in  WIDTH  operand A (dividend / mthi-mtlo source)
rt  in  WIDTH  operand B (divisor)
req  in  1  exception/interrupt taken this cycle; cancels
busy  out  1  operation in flight; upstream stalls mfhi/mflo/MDU ops
done  out  1  one-cycle pulse after a committing edge
dz  out  1  sticky: last div/divu had rt==0; cleared by next accepted div/divu
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset: state IDLE, counter 0, busy=0, done=0, dz=0, hi=0, lo=0. Reset mid-operation discards the op.
- States: IDLE, RUN.
- Accept: edge with start=1, busy=0, req=0, op in 1..10; otherwise start is ignored. start while busy is ignored: no queueing, no error.
- mthi/mtlo: on the accepting edge hi<=rs or lo<=rs; stay IDLE, busy stays 0, done=0.
- Arithmetic ops, on the accepting edge:
  - latch rs, rt, op
  - counter<=MULT_LAT or DIV_LAT
  - go RUN; busy=1 from the next cycle
- RUN:
  - Counter decrements each edge.
  - Edge with counter==1: commit hi/lo, go IDLE, busy=0, done=1 for exactly the following cycle.
  - busy is therefore high for exactly LAT cycles.
- Results (all modulo 2^(2*WIDTH); {hi,lo} is the concatenation):
  - mult/multu: {hi,lo}=signed/unsigned rs*rt.
  - madd(u)/msub(u): {hi,lo} = {hi,lo} ± signed/unsigned product, using HI/LO values at commit time.
  - div/divu: lo=quotient, hi=remainder. Signed division truncates toward zero; remainder takes the dividend's sign.
  - Signed MIN/-1: lo=MIN, hi=0.
- Divide by zero: hi/lo unchanged, dz<=1 at commit, done still pulses.
- req: while req=1, no op is accepted (including mthi/mtlo). If req=1 in RUN, the op aborts at that edge: go IDLE, busy=0 next cycle, no commit, no done, dz unchanged.
- req on the same edge as a would-be commit (counter==1): abort wins.
- After a commit or abort, a new op may be accepted on the very next edge (busy=0 that cycle).
- hi/lo change only on commit or mthi/mtlo edges. They are stable while busy.

Test Plan:
- multu, WIDTH=32, MULT_LAT=5: rs=0xFFFFFFFF, rt=2, start 1 cycle -> busy high 5 cycles; then hi=0x00000001, lo=0xFFFFFFFE, done pulses once.
- div, DIV_LAT=10: rs=-7, rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). rs=0x80000000, rt=-1 -> lo=0x80000000, hi=0. rs=5, rt=0 -> hi/lo unchanged, dz=1, done pulses.
- Accumulate: mthi 0, mtlo 0xFFFFFFFF, then madd rs=1, rt=1 -> hi=1, lo=0. Then msubu rs=1, rt=1 -> hi=0, lo=0xFFFFFFFF.
- Abort: mult rs=3, rt=4 with prior hi=lo=0x55; req=1 on cycle 3 of busy -> busy drops next cycle, no done, hi=lo=0x55. An identical start with req=1 on the issue edge is not accepted (busy stays 0).
- Back-to-back: second start asserted during busy is ignored. Start on the first cycle busy=0 after done is accepted. Async reset asserted mid-RUN -> busy=0, hi=lo=0, dz=0 immediately, without a clock edge.
- Parametrisation: WIDTH=16, MULT_LAT=1: mult rs=0x8000, rt=0x8000 -> busy for 1 cycle, hi=0x4000, lo=0x0000.
